// File: rtl/dds_phase_gen.sv
// rtl/dds_phase_gen.sv - DDS phase accumulator with handshaked FTW load, immediate or on-wrap apply.
// Optional phase dither LFSR is built when DDS_PHASE_DITHER_EN is defined.
module dds_phase_gen #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               sync,
  input  logic [ACC_W-1:0]   ftw_data,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  input  logic               apply_on_wrap,
  input  logic [PHASE_W-1:0] offset,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap
);
  localparam int FRAC_W = ACC_W - PHASE_W;

  typedef enum logic [1:0] {IDLE, RUN, PENDING} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   ftw_active_q, ftw_active_d;
  logic [ACC_W-1:0]   ftw_shadow_q, ftw_shadow_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   phase_sum;
  logic [ACC_W-1:0]   dither;
  logic               carry;
  logic               xfer;

  assign sum       = {1'b0, acc_q} + {1'b0, ftw_active_q};
  assign carry     = sum[ACC_W];
  assign ftw_ready = (state_q != PENDING);
  assign xfer      = ftw_valid && ftw_ready;
  assign phase_sum = acc_q + {offset, {FRAC_W{1'b0}}} + dither;

`ifdef DDS_PHASE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  always_comb begin
    lfsr_d = lfsr_q;
    if (sync) begin
      lfsr_d = 16'hACE1;
    end else if (ena) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  always_comb begin
    dither             = '0;
    dither[FRAC_W-1:0] = lfsr_q[FRAC_W-1:0];
  end
`else
  assign dither = '0;
`endif

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ftw_active_d = ftw_active_q;
    ftw_shadow_d = ftw_shadow_q;
    phase_d      = phase_q;
    wrap_d       = 1'b0;

    if (ena) begin
      acc_d   = sum[ACC_W-1:0];
      phase_d = phase_sum[ACC_W-1 -: PHASE_W];
      wrap_d  = carry;
    end
    if (sync) begin
      acc_d  = '0;
      wrap_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (xfer) begin
          ftw_active_d = ftw_data;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (apply_on_wrap) begin
            ftw_shadow_d = ftw_data;
            state_d      = PENDING;
          end else begin
            ftw_active_d = ftw_data;
          end
        end
      end
      PENDING: begin
        // Swap on the carrying add so the wrap step still uses the old word.
        if (sync || (ena && carry)) begin
          ftw_active_d = ftw_shadow_q;
          state_d      = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ftw_active_q <= '0;
      ftw_shadow_q <= '0;
      phase_q      <= '0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ftw_active_q <= ftw_active_d;
      ftw_shadow_q <= ftw_shadow_d;
      phase_q      <= phase_d;
      wrap_q       <= wrap_d;
    end
  end

  assign phase = phase_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// tb/tb_dds_phase_gen.sv - self-checking bench for dds_phase_gen against an arithmetic reference model.
module tb_dds_phase_gen;
  localparam int     ACC_W   = 24;
  localparam int     PHASE_W = 14;
  localparam longint MOD     = 64'd1 << ACC_W;
  localparam longint LSB_PH  = 64'd1 << (ACC_W - PHASE_W);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ena = 1'b0;
  logic               sync = 1'b0;
  logic [ACC_W-1:0]   ftw_data = '0;
  logic               ftw_valid = 1'b0;
  logic               ftw_ready;
  logic               apply_on_wrap = 1'b0;
  logic [PHASE_W-1:0] offset = '0;
  logic [PHASE_W-1:0] phase;
  logic               wrap;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  dds_phase_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .sync          (sync),
    .ftw_data      (ftw_data),
    .ftw_valid     (ftw_valid),
    .ftw_ready     (ftw_ready),
    .apply_on_wrap (apply_on_wrap),
    .offset        (offset),
    .phase         (phase),
    .wrap          (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: integer accumulator, pending flag, words held as plain numbers.
  longint m_acc = 0, m_active = 0, m_shadow = 0, m_phase = 0, m_total = 0, m_dith = 0;
  bit     m_pending = 0, m_started = 0, m_wrap = 0, m_carry = 0, m_lsb = 0;
  int     m_lfsr = 'hACE1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_active = 0; m_shadow = 0; m_phase = 0;
      m_pending = 0; m_started = 0; m_wrap = 0; m_lfsr = 'hACE1;
    end else begin
`ifdef DDS_PHASE_DITHER_EN
      m_dith = longint'(m_lfsr) % LSB_PH;
`else
      m_dith = 0;
`endif
      m_total = m_acc + m_active;
      m_carry = ena && (m_total >= MOD);
      if (ena) m_phase = ((m_acc + longint'(offset) * LSB_PH + m_dith) % MOD) / LSB_PH;
      m_wrap = m_carry && !sync;
      if (m_pending) begin
        if (sync || m_carry) begin
          m_active  = m_shadow;
          m_pending = 0;
        end
      end else if (ftw_valid) begin
        if (m_started && apply_on_wrap) begin
          m_shadow  = longint'(ftw_data);
          m_pending = 1;
        end else begin
          m_active = longint'(ftw_data);
        end
        m_started = 1;
      end
      if (sync)     m_acc = 0;
      else if (ena) m_acc = m_total % MOD;
      if (sync) begin
        m_lfsr = 'hACE1;
      end else if (ena) begin
        m_lsb  = m_lfsr[0];
        m_lfsr = m_lfsr >> 1;
        if (m_lsb) m_lfsr = m_lfsr ^ 'hB400;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_phase", longint'(phase), m_phase);
      chk("model_wrap", longint'(wrap), longint'(m_wrap));
      chk("model_ready", longint'(ftw_ready), longint'(!m_pending));
    end
  end

  int n;
  logic [31:0] rnd;

  initial begin
    #22;
    chk("reset_phase", longint'(phase), 0);
    chk("reset_wrap", longint'(wrap), 0);
    chk("reset_ready", longint'(ftw_ready), 1);
    rst_n = 1'b1;
    check_en = 1'b1;

    // FTW 0x400 from IDLE: phase 0,0,1,2,3 from the accept edge.
    ena = 1; ftw_valid = 1; ftw_data = 24'h000400; apply_on_wrap = 0; offset = '0;
    tick(1); ftw_valid = 0;
    chk("slow_ph0", longint'(phase), 0);
    tick(1); chk("slow_ph1", longint'(phase), 0);
    tick(1); chk("slow_ph2", longint'(phase), 1);
    tick(1); chk("slow_ph3", longint'(phase), 2);
    tick(1); chk("slow_ph4", longint'(phase), 3);
    n = 0;
    while (!wrap && n < 20000) begin tick(1); n++; end
    chk("slow_first_wrap", longint'(n), 16380);
    n = 0;
    do begin tick(1); n++; end while (!wrap && n < 20000);
    chk("slow_wrap_period", longint'(n), 16384);

    // FTW 0x400000 with offset 0x2000 after a sync clear.
    sync = 1; ftw_valid = 1; ftw_data = 24'h400000; offset = 14'h2000;
    tick(1); sync = 0; ftw_valid = 0;
    tick(1); chk("quad_ph1", longint'(phase), 'h2000);
    tick(1); chk("quad_ph2", longint'(phase), 'h3000);
    tick(1); chk("quad_ph3", longint'(phase), 'h0000);
    tick(1); chk("quad_ph4", longint'(phase), 'h1000);
    chk("quad_wrap4", longint'(wrap), 1);
    tick(4); chk("quad_wrap8", longint'(wrap), 1);

    // Deferred apply of 0x200000.
    ftw_valid = 1; ftw_data = 24'h200000; apply_on_wrap = 1; offset = '0;
    tick(1); ftw_valid = 0;
    chk("defer_ready_lo", longint'(ftw_ready), 0);
    tick(2); chk("defer_ready_hold", longint'(ftw_ready), 0);
    tick(1); chk("defer_wrap", longint'(wrap), 1);
    chk("defer_ready_hi", longint'(ftw_ready), 1);
    tick(1); chk("defer_ph0", longint'(phase), 0);
    tick(1); chk("defer_ph1", longint'(phase), 'h0800);
    tick(1); chk("defer_ph2", longint'(phase), 'h1000);

    // Transfer landing on the carry edge waits for the following wrap.
    tick(4); ftw_valid = 1; ftw_data = 24'h100000;
    tick(1); ftw_valid = 0;
    chk("coinc_wrap", longint'(wrap), 1);
    chk("coinc_ready", longint'(ftw_ready), 0);
    tick(2); chk("coinc_still_pend", longint'(ftw_ready), 0);
    tick(6); chk("coinc_wrap2", longint'(wrap), 1);
    chk("coinc_ready2", longint'(ftw_ready), 1);
    tick(1); chk("coinc_ph0", longint'(phase), 0);
    tick(1); chk("coinc_ph1", longint'(phase), 'h0400);

    // Sync while PENDING applies the shadow word.
    offset = 14'h1234; ftw_valid = 1; ftw_data = 24'h300000;
    tick(1); ftw_valid = 0;
    chk("sync_pend_ready", longint'(ftw_ready), 0);
    tick(2); sync = 1;
    tick(1); sync = 0;
    chk("sync_ready", longint'(ftw_ready), 1);
    chk("sync_wrap", longint'(wrap), 0);
    tick(1); chk("sync_ph_off", longint'(phase), 'h1234);
    tick(1); chk("sync_ph_step", longint'(phase), 'h1E34);

    ena = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("hold_phase", longint'(phase), 'h1E34);
      chk("hold_wrap", longint'(wrap), 0);
    end
    ena = 1;

    // Nyquist word wraps every second cycle.
    sync = 1; ftw_valid = 1; ftw_data = 24'h800000; apply_on_wrap = 0; offset = '0;
    tick(1); sync = 0; ftw_valid = 0;
    tick(1); chk("nyq_w1", longint'(wrap), 0);
    tick(1); chk("nyq_w2", longint'(wrap), 1);
    chk("nyq_ph2", longint'(phase), 'h2000);
    tick(1); chk("nyq_w3", longint'(wrap), 0);
    tick(1); chk("nyq_w4", longint'(wrap), 1);

    for (int i = 0; i < 4000; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      ftw_valid = ena && ($urandom_range(0, 2) == 0);
      apply_on_wrap = $urandom_range(0, 1);
      sync = ena && ($urandom_range(0, 96) == 0);
      rnd = $urandom;
      case ($urandom_range(0, 3))
        0: ftw_data = rnd[ACC_W-1:0];
        1: ftw_data = '0;
        2: ftw_data = 24'h800000;
        default: ftw_data = {rnd[7:0], 16'h0000};
      endcase
      if ($urandom_range(0, 19) == 0) offset = rnd[31:18];
      tick(1);
    end
    ena = 1; sync = 0; ftw_valid = 0;

    // Asynchronous reset between edges.
    #3 rst_n = 0;
    #2;
    chk("areset_phase", longint'(phase), 0);
    chk("areset_wrap", longint'(wrap), 0);
    chk("areset_ready", longint'(ftw_ready), 1);
    tick(2);
    rst_n = 1;
    ftw_valid = 1; ftw_data = 24'h000400; apply_on_wrap = 1; offset = '0;
    tick(1); ftw_valid = 0;
    chk("post_rst_ready", longint'(ftw_ready), 1);
    tick(1); chk("post_rst_ph1", longint'(phase), 0);
    tick(1); chk("post_rst_ph2", longint'(phase), 1);
    tick(5);

    check_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
